// File: rtl/uart_cmd_parser.sv
// ASCII monitor command-line parser: turns r/w/g/q lines from the UART receiver
// into memory read/write strobes, CPU run/stop pulses and hex-dump requests.
module uart_cmd_parser #(
  parameter int ADR_W  = 16,
  parameter int DAT_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rout,
  input  logic             rout_en,
  input  logic             flushing_wq,
  output logic [ADR_W-1:0] mem_adr,
  output logic [DAT_W-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [DAT_W-1:0] mem_rdata,
  output logic             rdata_snd_start,
  output logic [31:0]      rdata_snd,
  output logic             crlf_in,
  output logic             cpu_start,
  output logic             cpu_stop,
  output logic [ADR_W-1:0] start_adr,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ARG1, S_ARG2, S_ERR, S_EXEC, S_RDWAIT, S_SNDWAIT
  } state_t;

  typedef enum logic [1:0] {OP_R, OP_W, OP_G, OP_Q} op_t;

  state_t           state, state_nxt;
  op_t              op, op_dec;
  logic [ADR_W-1:0] adr_sr;
  logic [DAT_W-1:0] dat_sr;
  logic             dig1, dig2;
  logic [2:0]       cnt;

  logic [7:0] lc;
  logic [3:0] nib;
  logic       is_hex, is_sp, is_cr, is_op, ch_vld;

  logic op_ld, adr_clr, adr_shift, dat_clr, dat_shift;
  logic crlf_nxt, issue, rd_done;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lc = rout;
    if (rout >= 8'h41 && rout <= 8'h5a) lc = rout | 8'h20;
    is_sp  = (rout == 8'h20);
    is_cr  = (rout == 8'h0d);
    is_hex = 1'b1;
    nib    = '0;
    if (lc >= 8'h30 && lc <= 8'h39)      nib = 4'(lc - 8'h30);
    else if (lc >= 8'h61 && lc <= 8'h66) nib = 4'(lc - 8'h57);
    else                                 is_hex = 1'b0;
    is_op  = 1'b1;
    op_dec = OP_R;
    case (lc)
      8'h72:   op_dec = OP_R;
      8'h77:   op_dec = OP_W;
      8'h67:   op_dec = OP_G;
      8'h71:   op_dec = OP_Q;
      default: is_op  = 1'b0;
    endcase
  end

  // LF is invisible to every state; busy states never look at ch_vld.
  assign ch_vld = rout_en && (rout != 8'h0a);
  assign busy   = (state == S_EXEC) || (state == S_RDWAIT) || (state == S_SNDWAIT);

  always_comb begin
    state_nxt = state;
    op_ld     = 1'b0;
    adr_clr   = 1'b0;
    adr_shift = 1'b0;
    dat_clr   = 1'b0;
    dat_shift = 1'b0;
    crlf_nxt  = 1'b0;
    issue     = 1'b0;
    rd_done   = 1'b0;
    unique case (state)
      S_IDLE: if (ch_vld) begin
        if (is_op) begin
          op_ld     = 1'b1;
          state_nxt = S_CMD;
        end else if (is_cr) begin
          crlf_nxt = 1'b1;
        end else if (!is_sp) begin
          state_nxt = S_ERR;
        end
      end
      S_CMD: if (ch_vld) begin
        if (is_sp) begin
          adr_clr   = 1'b1;
          state_nxt = S_ARG1;
        end else if (is_cr && op == OP_Q) begin
          issue     = 1'b1;
          state_nxt = S_EXEC;
        end else if (is_cr) begin
          crlf_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_ARG1: if (ch_vld) begin
        if (is_hex) begin
          adr_shift = 1'b1;
        end else if (is_sp) begin
          if (dig1 && op == OP_W) begin
            dat_clr   = 1'b1;
            state_nxt = S_ARG2;
          end else if (dig1) begin
            state_nxt = S_ERR;
          end
        end else if (is_cr) begin
          // A malformed line still ends at its CR, so the prompt is not lost.
          if (dig1 && (op == OP_R || op == OP_G)) begin
            issue     = 1'b1;
            state_nxt = S_EXEC;
          end else begin
            crlf_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_ARG2: if (ch_vld) begin
        if (is_hex) begin
          dat_shift = 1'b1;
        end else if (is_cr) begin
          if (dig2) begin
            issue     = 1'b1;
            state_nxt = S_EXEC;
          end else begin
            crlf_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (!(is_sp && !dig2)) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: if (ch_vld && is_cr) begin
        crlf_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_EXEC:   state_nxt = (op == OP_R) ? S_RDWAIT : S_IDLE;
      S_RDWAIT: if (cnt == 3'd1) begin
        rd_done   = 1'b1;
        state_nxt = S_SNDWAIT;
      end
      S_SNDWAIT: if (flushing_wq) state_nxt = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Strobes are registered on the edge that enters EXEC, so they are high during the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op              <= OP_R;
      adr_sr          <= '0;
      dat_sr          <= '0;
      dig1            <= 1'b0;
      dig2            <= 1'b0;
      cnt             <= '0;
      mem_adr         <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      rdata_snd_start <= 1'b0;
      rdata_snd       <= '0;
      crlf_in         <= 1'b0;
      cpu_start       <= 1'b0;
      cpu_stop        <= 1'b0;
      start_adr       <= '0;
    end else begin
      if (op_ld) op <= op_dec;
      if (adr_clr) begin
        adr_sr <= '0;
        dig1   <= 1'b0;
      end else if (adr_shift) begin
        adr_sr <= {adr_sr[ADR_W-5:0], nib};
        dig1   <= 1'b1;
      end
      if (dat_clr) begin
        dat_sr <= '0;
        dig2   <= 1'b0;
      end else if (dat_shift) begin
        dat_sr <= {dat_sr[DAT_W-5:0], nib};
        dig2   <= 1'b1;
      end

      mem_we          <= issue && (op == OP_W);
      mem_re          <= issue && (op == OP_R);
      cpu_start       <= issue && (op == OP_G);
      cpu_stop        <= issue && (op == OP_Q);
      crlf_in         <= crlf_nxt || (issue && (op != OP_R));
      rdata_snd_start <= rd_done;

      if (issue && (op == OP_R || op == OP_W)) mem_adr <= adr_sr;
      if (issue && op == OP_W)                 mem_wdata <= dat_sr;
      if (issue && op == OP_G)                 start_adr <= adr_sr;

      if (issue)                  cnt <= 3'(RD_LAT);
      else if (state == S_RDWAIT) cnt <= cnt - 3'd1;
      if (rd_done)                rdata_snd <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected strobes are queued as lines are
// typed, and a negedge monitor's observed strobes are popped against them.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int ADR_W  = 16;
  localparam int DAT_W  = 32;
  localparam int RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rout = '0;
  logic             rout_en = 1'b0;
  logic             flushing_wq = 1'b0;
  logic [ADR_W-1:0] mem_adr;
  logic [DAT_W-1:0] mem_wdata;
  logic             mem_we, mem_re;
  logic [DAT_W-1:0] mem_rdata;
  logic             rdata_snd_start;
  logic [31:0]      rdata_snd;
  logic             crlf_in, cpu_start, cpu_stop;
  logic [ADR_W-1:0] start_adr;
  logic             busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rout(rout), .rout_en(rout_en), .flushing_wq(flushing_wq),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
    .crlf_in(crlf_in), .cpu_start(cpu_start), .cpu_stop(cpu_stop),
    .start_adr(start_adr), .busy(busy)
  );

  // Memory model with exactly one cycle of read latency.
  function automatic logic [31:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 32'h12345678 : {~a, a};
  endfunction

  always @(posedge clk) if (mem_re) mem_rdata <= mem_model(mem_adr);

  typedef enum logic [2:0] {EV_WE, EV_RE, EV_START, EV_STOP, EV_RSS, EV_CRLF} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] adr;
    logic [31:0] dat;
    int          cyc;
  } ev_t;

  ev_t obs_arr[1024];
  int  obs_wr = 0;
  int  cyc = 0;
  ev_t exp_q[$];
  int  obs_rd = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  last_re_cyc = 0;
  int  last_rss_cyc = 0;

  task automatic record(input ev_kind_t k, input logic [15:0] a, input logic [31:0] d);
    if (obs_wr < 1024) begin
      obs_arr[obs_wr] = '{k, a, d, cyc};
      obs_wr++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mem_we)          record(EV_WE, mem_adr, mem_wdata);
    if (mem_re)          record(EV_RE, mem_adr, '0);
    if (cpu_start)       record(EV_START, start_adr, '0);
    if (cpu_stop)        record(EV_STOP, '0, '0);
    if (rdata_snd_start) record(EV_RSS, '0, rdata_snd);
    if (crlf_in)         record(EV_CRLF, '0, '0);
  end

  task automatic expect_ev(input ev_kind_t k, input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back('{k, a, d, 0});
  endtask

  task automatic send_char(input logic [7:0] c, input bit force_it);
    int n = 0;
    while (!force_it && busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: busy=%b required 0", busy);
    end
    rout = c; rout_en = 1'b1;
    @(posedge clk); #1;
    rout_en = 1'b0; rout = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
  endtask

  task automatic wait_rss(input string name);
    int n = 0;
    @(negedge clk);
    while (rdata_snd_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rdata_snd_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rss_timeout: rdata_snd_start=%b required 1", name, rdata_snd_start);
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flushing_wq = 1'b1;
    @(posedge clk); #1 flushing_wq = 1'b0;
  endtask

  // Waits for idle, then pops every expected strobe against the observed log.
  task automatic drain(input string name);
    int  n = 0;
    ev_t e, o;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b required 0", name, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rd == obs_wr) begin
        n_fail++;
        $display("FAIL %s missing: no strobe seen, required kind=%s adr=%h dat=%h",
                 name, e.kind.name(), e.adr, e.dat);
      end else begin
        o = obs_arr[obs_rd];
        obs_rd++;
        if (o.kind == EV_RE)  last_re_cyc  = o.cyc;
        if (o.kind == EV_RSS) last_rss_cyc = o.cyc;
        if (o.kind !== e.kind || o.adr !== e.adr || o.dat !== e.dat) begin
          n_fail++;
          $display("FAIL %s event: got kind=%s adr=%h dat=%h, required kind=%s adr=%h dat=%h",
                   name, o.kind.name(), o.adr, o.dat, e.kind.name(), e.adr, e.dat);
        end
      end
    end
    n_checks++;
    if (obs_wr != obs_rd) begin
      n_fail++;
      $display("FAIL %s extra: %0d unexpected strobes, required 0", name, obs_wr - obs_rd);
    end
    obs_rd = obs_wr;
  endtask

  task automatic check_all_zero(input string name);
    logic [127:0] v;
    v = {mem_adr, mem_wdata, mem_we, mem_re, rdata_snd_start, rdata_snd,
         crlf_in, cpu_start, cpu_stop, start_adr, busy};
    n_checks++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got %h required 0", name, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("after_reset");
  endtask

  task automatic test_write();
    expect_ev(EV_WE, 16'h0010, 32'hdeadbeef);
    expect_ev(EV_CRLF, '0, '0);
    send_str("w 0010 deadBEEF\015");
    drain("write");
    n_checks++;
    if (mem_adr !== 16'h0010 || mem_wdata !== 32'hdeadbeef) begin
      n_fail++;
      $display("FAIL write_hold: adr=%h wdata=%h required 0010 deadbeef", mem_adr, mem_wdata);
    end
  endtask

  task automatic test_read();
    expect_ev(EV_RE, 16'h0010, '0);
    expect_ev(EV_RSS, '0, 32'h12345678);
    send_str("r 0010\015");
    wait_rss("read");
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_busy: busy=%b required 1", busy);
    end
    send_char("x", 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rdata_snd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_hold: busy=%b rdata_snd=%h required 1 12345678", busy, rdata_snd);
    end
    pulse_flush();
    drain("read");
    n_checks++;
    if (last_rss_cyc - last_re_cyc != RD_LAT + 1) begin
      n_fail++;
      $display("FAIL read_latency: got %0d cycles required %0d", last_rss_cyc - last_re_cyc, RD_LAT + 1);
    end
    // The dropped 'x' must not have left the parser in ERR.
    expect_ev(EV_STOP, '0, '0);
    expect_ev(EV_CRLF, '0, '0);
    send_str("q\015");
    drain("after_dropped_x");
  endtask

  task automatic test_go_stop();
    expect_ev(EV_START, 16'h2345, '0);
    expect_ev(EV_CRLF, '0, '0);
    send_str("g 12345\015");
    drain("go");
    expect_ev(EV_STOP, '0, '0);
    expect_ev(EV_CRLF, '0, '0);
    send_str("q\015");
    drain("stop");
    n_checks++;
    if (start_adr !== 16'h2345) begin
      n_fail++;
      $display("FAIL start_adr_hold: got %h required 2345", start_adr);
    end
  endtask

  task automatic test_errors();
    string lines[4] = '{"z 00\015", "r \015", "w 10\015", "r 1g\015"};
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_CRLF, '0, '0);
      send_str(lines[i]);
      drain($sformatf("err%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    send_str("r 00");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("mid_reset");
    rst_n = 1'b1;
    expect_ev(EV_CRLF, '0, '0);
    send_str("\015");
    drain("mid_reset_empty");
    expect_ev(EV_RE, 16'h0004, '0);
    expect_ev(EV_RSS, '0, mem_model(16'h0004));
    send_str("r 0004\015");
    wait_rss("mid_reset_read");
    pulse_flush();
    drain("mid_reset_read");
  endtask

  task automatic test_lf();
    expect_ev(EV_CRLF, '0, '0);
    send_str("\015\012");
    drain("cr_lf");
    expect_ev(EV_RE, 16'h00a0, '0);
    expect_ev(EV_RSS, '0, mem_model(16'h00a0));
    send_str("R 00A0\015");
    send_char(8'h0a, 1'b1);
    wait_rss("upper_read");
    pulse_flush();
    drain("upper_read");
    expect_ev(EV_WE, 16'h00b1, 32'h0000c2d3);
    expect_ev(EV_CRLF, '0, '0);
    send_str("W \012b1 C2\012d3\015");
    drain("lf_midline");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_go_stop();
    test_errors();
    test_reset_mid();
    test_lf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the received-character stream from the UART monitor interface (`rout`/`rout_en`) and parses ASCII monitor command lines.
- Issues memory read/write requests toward the CPU memory bus and CPU run/stop controls.
- Hands read results back to the UART interface for hex dump (`rdata_snd_start`/`rdata_snd`) and requests CR/LF output.
- Sits directly downstream of the UART interface and upstream of the memory/CPU control mux.

Parameters:
- ADR_W, 16: address width; the number of hex digits kept is ADR_W/4.
- DAT_W, 32: data width; the number of hex digits kept is DAT_W/4. Fixed at 32 to match `rdata_snd`.
- RD_LAT, 1: cycles from `mem_re` to valid `mem_rdata` (range 1..7).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rout  in  8  received ASCII character
- rout_en  in  1  one-cycle strobe, `rout` valid
- flushing_wq  in  1  UART interface has finished its send sequence (one-cycle pulse)
- mem_adr  out  ADR_W  memory address
- mem_wdata  out  DAT_W  write data
- mem_we  out  1  write strobe, one cycle
- mem_re  out  1  read strobe, one cycle
- mem_rdata  in  DAT_W  read data
- rdata_snd_start  out  1  one-cycle pulse, start hex dump of `rdata_snd`
- rdata_snd  out  32  data to dump
- crlf_in  out  1  one-cycle pulse, send CR LF
- cpu_start  out  1  one-cycle pulse, start CPU at `start_adr`
- cpu_stop  out  1  one-cycle pulse, halt CPU
- start_adr  out  ADR_W  CPU start address, held until the next g command
- busy  out  1  parser is executing or waiting; characters are dropped while high

Behaviour:
- **Reset.** All outputs are 0. State is IDLE. Address and data shift registers are 0.

- **Character classes (case-insensitive).**
  - Hex: 0-9, a-f, A-F.
  - Separator: space (0x20).
  - Terminator: CR (0x0d).
  - LF (0x0a) is ignored in every state.

- **Commands.**
  - `r AAAA<CR>`: read.
  - `w AAAA DDDDDDDD<CR>`: write.
  - `g AAAA<CR>`: go.
  - `q<CR>`: stop.
  - Digit counts are free. The shift register keeps the last ADR_W/4 (or DAT_W/4) digits, so earlier digits shift out the top. Fewer digits are zero-extended.

- **States:** IDLE, CMD, ARG1, ARG2, ERR, EXEC, RDWAIT, SNDWAIT.

- **IDLE** (each transition below occurs on `rout_en`):
  - r/w/g/q: latch the opcode, go to CMD.
  - Space: stay in IDLE.
  - CR: pulse `crlf_in`, stay in IDLE (empty line).
  - Anything else: go to ERR.

- **CMD:**
  - Space: go to ARG1 and clear the address register.
  - CR with opcode q: go to EXEC.
  - CR with any other opcode: pulse `crlf_in`, go to IDLE.
  - Anything else: go to ERR.

- **ARG1:**
  - Hex: `adr <= {adr, nibble}` and set `dig1`.
  - Space after at least one digit, opcode w: go to ARG2 and clear the data register.
  - Extra spaces before the first digit are ignored.
  - CR with `dig1` set and opcode r/g: go to EXEC.
  - Any other combination: go to ERR.

- **ARG2:**
  - Hex: shift into the data register and set `dig2`.
  - CR with `dig2` set: go to EXEC.
  - Spaces before the first digit are ignored.
  - Anything else: go to ERR.

- **ERR:** swallow characters until CR, then pulse `crlf_in` and go to IDLE.

- **EXEC** (one cycle, `busy` = 1):
  - r: drive `mem_adr`, pulse `mem_re`, load a counter with RD_LAT, go to RDWAIT.
  - w: drive `mem_adr` and `mem_wdata`, pulse `mem_we`, pulse `crlf_in`, go to IDLE.
  - g: `start_adr <= adr`, pulse `cpu_start` in the same cycle `start_adr` updates, pulse `crlf_in`, go to IDLE.
  - q: pulse `cpu_stop` and `crlf_in`, go to IDLE.

- **RDWAIT:**
  - Decrement the counter each cycle.
  - When it reaches 0, capture `mem_rdata` into `rdata_snd`, pulse `rdata_snd_start`, go to SNDWAIT.
  - Total latency from the EXEC cycle to `rdata_snd_start` is RD_LAT+1 cycles.

- **SNDWAIT:** hold `rdata_snd` stable until `flushing_wq`, then go to IDLE.

- **busy** = 1 in EXEC, RDWAIT and SNDWAIT. A `rout_en` arriving while `busy` is high is dropped and does not change state.

- **Output timing.**
  - `mem_adr` holds the last issued address and `mem_wdata` the last write data.
  - All pulse outputs are registered and exactly one cycle wide.
  - `crlf_in` and `rdata_snd_start` are never asserted in the same cycle.

- **Reset mid-command.** The partial line is discarded. No strobes are emitted after `rst_n` rises until a new complete line arrives.

Test Plan:
- `"w 0010 deadBEEF\r"` -> exactly one `mem_we` with `mem_adr`=0x0010 and `mem_wdata`=0xdeadbeef, followed by one `crlf_in`; `busy` drops to 0.
- `"r 0010\r"` with `mem_rdata`=0x12345678, RD_LAT=1 -> `mem_re` at EXEC, `rdata_snd_start` 2 cycles later with `rdata_snd`=0x12345678. `busy` stays high until `flushing_wq`. An `'x'` sent during SNDWAIT is ignored.
- `"g 12345\r"` -> `start_adr`=0x2345 (last 4 digits), one `cpu_start` pulse and one `crlf_in`. Then `"q\r"` -> one `cpu_stop` pulse and one `crlf_in`.
- Error lines: `"z 00\r"`, `"r \r"`, `"w 10\r"` and `"r 1g\r"` -> each gives exactly one `crlf_in` with no `mem_we`, `mem_re` or `cpu_*` pulse; state returns to IDLE.
- `"r 00"` then `rst_n` low for 2 cycles, then `"\r"` -> all outputs are 0 and a single `crlf_in` (empty line) is produced. A following `"r 0004\r"` issues `mem_re` with `mem_adr`=4.
- LF handling: `"\r\n"` -> one `crlf_in`, and the LF is ignored. `"R 00A0\r\n"` (uppercase) behaves exactly like `"r 00a0\r"`.
